// File: rtl/zbritesi_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the width of the bit counter.
package zbritesi_serial_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_FIN_ENC   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC,
    ST_FIN   = ST_FIN_ENC
  } state_t;

  // Counter must hold 0..width so a degenerate width still yields one bit.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/zbritesi1b.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with borrow-out.
module zbritesi1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/zbritesi_serial.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per
// clock, with a start/ready/busy/done handshake toward the controlling FSM.
module zbritesi_serial
  import zbritesi_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int              CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   diff_next;
  logic               br;
  logic               a_msb;
  logic               b_msb;
  logic               d_bit;
  logic               br_next;

  zbritesi1b u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  // Result bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign diff_next = d_bit;
    end else begin : g_diff_wn
      assign diff_next = {d_bit, diff[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      br    <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            state <= ST_SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          diff <= diff_next;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            // d_bit is the result MSB on this last edge; overflow uses loaded sign bits.
            state <= ST_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= br_next;
            ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zbritesi_serial.sv
// Self-checking bench for zbritesi_serial: scoreboard of expected results pushed
// at accept time and popped when DONE pulses; WIDTH=8 plus a WIDTH=1 instance.
module tb_zbritesi_serial;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         ready, busy, done, bout, ovf;
  logic [W-1:0] diff;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         bin1 = 1'b0;
  logic         ready1, busy1, done1, bout1, ovf1;
  logic [0:0]   diff1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  zbritesi_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  zbritesi_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
    exp_t m;
    logic [W:0] full;
    full   = {1'b0, ai} - {1'b0, bi} - {{W{1'b0}}, bini};
    m.diff = full[W-1:0];
    m.bout = full[W];
    m.ovf  = (ai[W-1] != bi[W-1]) && (full[W-1] != ai[W-1]);
    return m;
  endfunction

  // Issue one op, verify DONE lands exactly WIDTH edges after accept, compare result.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                        input string name);
    exp_t e;
    int   done_k;
    done_k = -1;
    @(negedge clk);
    a = ai; b = bi; bin = bini; start = 1'b1;
    total_cnt++;
    if (ready !== 1'b1) $display("FAIL %s ready_before_accept got=%b want=1", name, ready);
    else pass_cnt++;
    sbq.push_back(model(ai, bi, bini));
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && done_k < 0) begin
        done_k = k;
        total_cnt++;
        if (sbq.size() == 0) begin
          $display("FAIL %s scoreboard_empty got=done want=no_done", name);
        end else begin
          e = sbq.pop_front();
          if (diff !== e.diff || bout !== e.bout || ovf !== e.ovf)
            $display("FAIL %s result got=%h/%b/%b want=%h/%b/%b", name, diff, bout, ovf,
                     e.diff, e.bout, e.ovf);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (done_k !== W) $display("FAIL %s done_cycle got=%0d want=%0d", name, done_k, W);
    else pass_cnt++;
    total_cnt++;
    if (ready !== 1'b1 || done !== 1'b0) $display("FAIL %s idle_after got=r%b/d%b want=r1/d0", name, ready, done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_ctrl got=r%b/b%b/d%b want=r1/b0/d0", ready, busy, done);
    else pass_cnt++;
    total_cnt++;
    if (diff !== '0 || bout !== 1'b0 || ovf !== 1'b0)
      $display("FAIL reset_data got=%h/%b/%b want=00/0/0", diff, bout, ovf);
    else pass_cnt++;
    total_cnt++;
    if (ready1 !== 1'b1 || diff1 !== 1'b0) $display("FAIL reset_w1 got=r%b/%b want=r1/0", ready1, diff1);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(8'h5A, 8'h3C, 1'b0, "basic");
    total_cnt++;
    if (diff !== 8'h1E) $display("FAIL basic_hold got=%h want=1e", diff);
    else pass_cnt++;
  endtask

  task automatic test_boundaries();
    run_op(8'h00, 8'h01, 1'b0, "underflow");
    run_op(8'h80, 8'h01, 1'b0, "signed_ovf");
    run_op(8'h10, 8'h0F, 1'b1, "borrow_in");
    run_op(8'h33, 8'h33, 1'b1, "equal_bin");
    run_op(8'h7F, 8'hFF, 1'b0, "pos_minus_neg");
    run_op(8'hFF, 8'h00, 1'b1, "all_ones");
  endtask

  // START held high: second accept only after the FIN->IDLE cycle; mid-op input changes ignored.
  task automatic test_back_to_back();
    exp_t e;
    int   done_k;
    done_k = -1;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    sbq.push_back(model(8'h5A, 8'h3C, 1'b0));
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin a = 8'h80; b = 8'h01; bin = 1'b1; end
      if (k <= 9) begin
        total_cnt++;
        if (ready !== (k == 9)) $display("FAIL b2b_ready k=%0d got=%b want=%b", k, ready, (k == 9));
        else pass_cnt++;
      end
      if (k == 8) begin
        total_cnt++;
        if (done !== 1'b1) $display("FAIL b2b_done1 got=%b want=1", done);
        else pass_cnt++;
        total_cnt++;
        if (sbq.size() == 0) $display("FAIL b2b_result1 scoreboard_empty got=done want=entry");
        else begin
          e = sbq.pop_front();
          if (diff !== e.diff || bout !== e.bout || ovf !== e.ovf)
            $display("FAIL b2b_result1 got=%h/%b/%b want=%h/%b/%b", diff, bout, ovf, e.diff, e.bout, e.ovf);
          else pass_cnt++;
        end
      end
      if (k == 9) sbq.push_back(model(a, b, bin));
      if (k == 10) begin
        total_cnt++;
        if (busy !== 1'b1 || ready !== 1'b0) $display("FAIL b2b_accept2 got=b%b/r%b want=b1/r0", busy, ready);
        else pass_cnt++;
        start = 1'b0;
      end
    end
    for (int k = 11; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && done_k < 0) begin
        done_k = k;
        total_cnt++;
        if (sbq.size() == 0) $display("FAIL b2b_result2 scoreboard_empty got=done want=entry");
        else begin
          e = sbq.pop_front();
          if (diff !== e.diff || bout !== e.bout || ovf !== e.ovf)
            $display("FAIL b2b_result2 got=%h/%b/%b want=%h/%b/%b", diff, bout, ovf, e.diff, e.bout, e.ovf);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (done_k !== 18) $display("FAIL b2b_done2_cycle got=%0d want=18", done_k);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    a = 8'hC3; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || diff !== '0)
      $display("FAIL abort_state got=r%b/b%b/d%b/%h want=r1/b0/d0/00", ready, busy, done, diff);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'hA5, 8'h5B, 1'b0, "after_abort");
    total_cnt++;
    if (sbq.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", sbq.size());
    else pass_cnt++;
  endtask

  task automatic test_width1();
    int done_k;
    done_k = -1;
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1 && done_k < 0) begin
        done_k = k;
        total_cnt++;
        if (diff1 !== 1'b1 || bout1 !== 1'b1 || ovf1 !== 1'b1)
          $display("FAIL w1_result got=%b/%b/%b want=1/1/1", diff1, bout1, ovf1);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (done_k !== 1) $display("FAIL w1_done_cycle got=%0d want=1", done_k);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_abort();
    test_width1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
